// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the band-fetch producers, the write arbiter and the FIFO write side.
// The master drives requests and the FIFO full flag; the slave is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
);
  localparam int unsigned GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_data;
  logic                     grant_valid;
  logic [GW-1:0]            grant_id;
  logic                     burst_done;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data, grant_valid, grant_id, burst_done
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data, grant_valid, grant_id, burst_done
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// A winner owns the port until its last beat or MAX_BURST accepted beats.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int unsigned GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    rr_ptr, rr_ptr_d;
  logic [GW-1:0]    owner, owner_d;
  logic [CW-1:0]    beat_cnt, beat_cnt_d;
  logic [GW-1:0]    pick;
  logic             pick_hit;
  logic [GW:0]      cand;
  logic [WIDTH-1:0] slice [NUM_REQ];

  logic [NUM_REQ-1:0] ready_c;
  logic               wr_en_c;
  logic [WIDTH-1:0]   data_c;
  logic               done_c;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = bus.req_data[g*WIDTH +: WIDTH];
  end

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick     = '0;
    pick_hit = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_REQ)) cand = cand - (GW+1)'(NUM_REQ);
      if (!pick_hit && bus.req_valid[GW'(cand)]) begin
        pick_hit = 1'b1;
        pick     = GW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr;
    owner_d    = owner;
    beat_cnt_d = beat_cnt;
    ready_c    = '0;
    wr_en_c    = 1'b0;
    data_c     = '0;
    done_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        ready_c[owner] = !bus.fifo_full;
        data_c         = slice[owner];
        wr_en_c        = bus.req_valid[owner] && !bus.fifo_full;
        if (wr_en_c) begin
          beat_cnt_d = beat_cnt + CW'(1);
          // last marker and cap on the same beat still give a single release
          if (bus.req_last[owner] || (beat_cnt_d == CW'(MAX_BURST))) begin
            done_c   = 1'b1;
            state_d  = IDLE;
            rr_ptr_d = (owner == GW'(NUM_REQ - 1)) ? '0 : owner + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr   <= rr_ptr_d;
      owner    <= owner_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.fifo_wr_en  = wr_en_c;
  assign bus.fifo_data   = data_c;
  assign bus.burst_done  = done_c;
  assign bus.grant_valid = (state_q == BURST);
  assign bus.grant_id    = (state_q == BURST) ? owner : '0;
endmodule
